mem_req_ctrl: RTL and testbench
===============================

Name: mem_req_ctrl

Overview:
Request front-end that sits directly upstream of the team's 10-word × 32-bit asynchronous-read register memory. It converts a valid/ready request stream into that memory's enable/addr/Data_in controls. It samples the memory's Data_out on reads and returns a valid/ready response carrying read data or an address error. All memory sequencing is owned here, so the memory itself stays purely combinational.

Parameters:
DEPTH, 10, number of memory words; addresses ≥ DEPTH are errors.
AW, 4, address width.
DW, 32, data width.
WR_CYCLES, 1, cycles mem_enable is held high per write (≥1).
RD_WAIT, 1, cycles address is held with mem_enable low before read-data capture (≥1).

Ports:
clk  in  1  single clock, all state on rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request.
req_write  in  1  1 = write, 0 = read.
req_addr  in  AW  word address.
req_wdata  in  DW  write data.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts response.
rsp_rdata  out  DW  read data; 0 for writes and errors.
rsp_err  out  1  address out of range.
mem_enable  out  1  to memory enable (1 = write).
mem_addr  out  AW  to memory addr.
mem_wdata  out  DW  to memory Data_in.
mem_rdata  in  DW  from memory Data_out.
txn_count  out  16  completed responses, saturating.
err_count  out  8  error responses, saturating.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset: state IDLE. The following are all 0: req_ready, rsp_valid, rsp_rdata, rsp_err, mem_enable, mem_addr, mem_wdata, txn_count, err_count. req_ready rises in the first cycle after rst deasserts.
- FSM states: IDLE, WR, RD, RESP.
  - req_ready = (state == IDLE).
  - mem_enable = (state == WR).
  - rsp_valid = (state == RESP).
- IDLE: on an edge with req_valid && req_ready:
  - Latch addr, wdata and the write flag into mem_addr and mem_wdata.
  - If addr ≥ DEPTH → RESP with rsp_err=1 and rsp_rdata=0. No memory access occurs: mem_enable never rises.
  - Else if write → WR, cycle counter=0.
  - Else → RD, cycle counter=0.
- WR: mem_enable=1 with mem_addr/mem_wdata stable. After WR_CYCLES cycles → RESP with rsp_rdata=0, rsp_err=0.
- RD: mem_enable=0, mem_addr stable. On the edge ending the RD_WAIT-th cycle, capture mem_rdata into rsp_rdata, set rsp_err=0, → RESP.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready. On an edge with rsp_ready → IDLE and:
  - txn_count += 1, saturating at 0xFFFF.
  - err_count += 1 if rsp_err, saturating at 0xFF.
- Latency (request accepted on edge k):
  - Write: mem_enable high in cycles k+1..k+WR_CYCLES; rsp_valid from cycle k+WR_CYCLES+1.
  - Read: rsp_valid from cycle k+RD_WAIT+1.
  - Error: rsp_valid from cycle k+1.
  - Minimum request-to-request spacing is latency+1 cycles. No new request is accepted while a response is outstanding.
- mem_addr and mem_wdata keep their last values in IDLE and RESP (no glitch to 0).
- Backpressure: rsp_ready may be held low indefinitely; the FSM stays in RESP with outputs frozen.
- Simultaneous events: rst wins over every handshake. A response handshaked in the same edge as rst is not counted.
- Reset mid-operation: any state → IDLE at the sampling edge. mem_enable is low from the next cycle. A partially completed write may have updated memory; this is acceptable and not reported.
- req_* inputs are don't-care when req_ready=0.

Test Plan:
- Reset then write addr 3 = 0xDEADBEEF → mem_enable high exactly 1 cycle with mem_addr=3 and mem_wdata=0xDEADBEEF; rsp_valid next cycle with rsp_rdata=0, rsp_err=0; txn_count=1 after handshake.
- Write addr 9 = 0x12345678, then read addr 9 → rsp_rdata=0x12345678 two cycles after read acceptance; mem_enable stays 0 throughout the read.
- Request addr 10 and addr 15, both read and write → rsp_err=1 one cycle after acceptance, rsp_rdata=0, mem_enable never asserted; err_count increments per error.
- Read response with rsp_ready held low 20 cycles → rsp_valid, rsp_rdata and rsp_err stable, req_ready=0 throughout; one txn_count increment on release.
- Assert rst during WR with WR_CYCLES=4 → next cycle state IDLE: mem_enable=0, req_ready=1, counters 0; a follow-up read returns a correct value.
- Issue 0x10005 back-to-back error responses → txn_count saturates at 0xFFFF and err_count at 0xFF, with no wrap to 0.

Source files
------------

// File: rtl/mem_req_ctrl.sv
// -----------------------------------------------------------------------------
// mem_req_ctrl
//
// Request front-end for the 10-word x 32-bit asynchronous-read register
// memory. Turns a valid/ready request stream into the memory's
// enable/addr/Data_in controls and returns one valid/ready response per
// request. The response carries read data or an address-range error. All
// memory sequencing lives here, so the memory itself stays purely
// combinational.
//
// Ports
//   clk, rst      : single clock; synchronous active-high reset
//   req_valid     : request present
//   req_ready     : controller can accept a request (IDLE only)
//   req_write     : 1 = write, 0 = read
//   req_addr      : word address (>= DEPTH is an error)
//   req_wdata     : write data
//   rsp_valid     : response present (RESP state)
//   rsp_ready     : consumer accepts the response
//   rsp_rdata     : read data; 0 for writes and errors
//   rsp_err       : address was out of range
//   mem_enable    : memory write enable, high for WR_CYCLES per write
//   mem_addr      : memory address, held from acceptance until next request
//   mem_wdata     : memory Data_in, held from acceptance until next request
//   mem_rdata     : memory Data_out (asynchronous read)
//   txn_count     : completed responses, saturating at 0xFFFF
//   err_count     : error responses, saturating at 0xFF
// -----------------------------------------------------------------------------
module mem_req_ctrl #(
    parameter int DEPTH     = 10,
    parameter int AW        = 4,
    parameter int DW        = 32,
    parameter int WR_CYCLES = 1,
    parameter int RD_WAIT   = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          mem_enable,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   txn_count,
    output logic [7:0]    err_count
);

    // Phase counter wide enough for any practical WR_CYCLES / RD_WAIT.
    localparam int             CW      = 16;
    localparam logic [CW-1:0]  WR_LAST = CW'(WR_CYCLES - 1);
    localparam logic [CW-1:0]  RD_LAST = CW'(RD_WAIT - 1);
    // One extra bit so DEPTH == 2**AW still compares correctly.
    localparam logic [AW:0]    DEPTH_V = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cyc;
    logic          addr_bad;
    logic          accept;
    logic          rd_capture;
    logic          rsp_done;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign addr_bad = ({1'b0, req_addr} >= DEPTH_V);

    // Next-state and handshake decode. req_ready is also gated by rst so
    // nothing is accepted while reset is asserted, and it rises as soon as
    // rst drops because the state is already IDLE.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        rd_capture = 1'b0;
        rsp_done   = 1'b0;
        req_ready  = (state == IDLE) && !rst;
        mem_enable = (state == WR);
        rsp_valid  = (state == RESP);

        unique case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    if (addr_bad) begin
                        state_nxt = RESP;
                    end else if (req_write) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            WR: begin
                if (cyc == WR_LAST) begin
                    state_nxt = RESP;
                end
            end
            RD: begin
                // Address has been stable for RD_WAIT cycles; the memory's
                // asynchronous output is settled and is sampled on this edge.
                if (cyc == RD_LAST) begin
                    rd_capture = 1'b1;
                    state_nxt  = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request latch, response capture and statistics. Reset takes priority,
    // so a response handshaked on a reset edge is never counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            txn_count <= '0;
            err_count <= '0;
        end else begin
            if (accept) begin
                // Error requests still latch the address/data, but never
                // reach WR, so the memory is not touched.
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata;
                rsp_rdata <= '0;
                rsp_err   <= addr_bad;
                cyc       <= '0;
            end else if (state == WR || state == RD) begin
                cyc <= cyc + 1'b1;
            end

            if (rd_capture) begin
                rsp_rdata <= mem_rdata;
            end

            if (rsp_done) begin
                txn_count <= sat_inc16(txn_count);
                if (rsp_err) begin
                    err_count <= sat_inc8(err_count);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_req_ctrl
//
// Bench for mem_req_ctrl. Two instances share one clock:
//   u_dut   : default timing (WR_CYCLES=1, RD_WAIT=1), main traffic
//   u_dut_b : WR_CYCLES=4, RD_WAIT=2, reset-during-write scenario
// Each instance drives a small emulation of the asynchronous-read memory.
// Expected responses come from a transaction-level model: a golden copy of
// memory contents, latency/enable-count rules and saturating counters.
// -----------------------------------------------------------------------------
module tb_mem_req_ctrl;

    localparam int DEPTH = 10;
    localparam int WR_A  = 1;
    localparam int RD_A  = 1;
    localparam int WR_B  = 4;
    localparam int RD_B  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A signals ----------------
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_enable;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [15:0] txn_count;
    logic [7:0]  err_count;

    // ---------------- instance B signals ----------------
    logic        rst_b;
    logic        req_valid_b, req_ready_b, req_write_b;
    logic [3:0]  req_addr_b;
    logic [31:0] req_wdata_b;
    logic        rsp_valid_b, rsp_ready_b, rsp_err_b;
    logic [31:0] rsp_rdata_b;
    logic        mem_enable_b;
    logic [3:0]  mem_addr_b;
    logic [31:0] mem_wdata_b, mem_rdata_b;
    logic [15:0] txn_count_b;
    logic [7:0]  err_count_b;

    mem_req_ctrl #(
        .DEPTH(DEPTH), .AW(4), .DW(32), .WR_CYCLES(WR_A), .RD_WAIT(RD_A)
    ) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .txn_count(txn_count), .err_count(err_count)
    );

    mem_req_ctrl #(
        .DEPTH(DEPTH), .AW(4), .DW(32), .WR_CYCLES(WR_B), .RD_WAIT(RD_B)
    ) u_dut_b (
        .clk(clk), .rst(rst_b),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b),
        .rsp_err(rsp_err_b),
        .mem_enable(mem_enable_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata_b),
        .txn_count(txn_count_b), .err_count(err_count_b)
    );

    // Memory emulations: combinational read, write on clock edge while enabled.
    logic [31:0] mem_a [DEPTH];
    logic [31:0] mem_b [DEPTH];

    assign mem_rdata   = (int'(mem_addr)   < DEPTH) ? mem_a[mem_addr]   : 32'h0;
    assign mem_rdata_b = (int'(mem_addr_b) < DEPTH) ? mem_b[mem_addr_b] : 32'h0;

    always @(posedge clk) begin
        if (mem_enable && int'(mem_addr) < DEPTH) mem_a[mem_addr] <= mem_wdata;
        if (mem_enable_b && int'(mem_addr_b) < DEPTH) mem_b[mem_addr_b] <= mem_wdata_b;
    end

    // Reference model state
    logic [31:0] gold [DEPTH];
    int          exp_txn;
    int          exp_err;
    int          checks;
    int          failures;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on instance A, checked against the model.
    task automatic do_txn(input bit wr, input logic [3:0] addr,
                          input logic [31:0] wdata, input int hold);
        bit          bad;
        int          exp_lat;
        int          lat;
        int          en_cnt;
        logic [31:0] exp_rd;

        bad     = (int'(addr) >= DEPTH);
        exp_lat = bad ? 1 : (wr ? WR_A + 1 : RD_A + 1);
        exp_rd  = 32'h0;
        if (!bad && !wr) exp_rd = gold[addr];

        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        // Inputs are don't-care once accepted; scramble them.
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 4'($urandom);
        req_wdata = $urandom;

        lat    = 1;
        en_cnt = 0;
        while (rsp_valid !== 1'b1 && lat <= 40) begin
            if (mem_enable === 1'b1) begin
                en_cnt++;
                check("wr_addr", 32'(mem_addr), 32'(addr));
                check("wr_data", mem_wdata, wdata);
            end
            check("ready_busy", 32'(req_ready), 32'd0);
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("enable_cycles", 32'(en_cnt), (wr && !bad) ? 32'(WR_A) : 32'd0);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_err", 32'(rsp_err), 32'(bad));
        if (wr && !bad) gold[addr] = wdata;

        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, exp_rd);
            check("hold_err", 32'(rsp_err), 32'(bad));
            check("hold_ready", 32'(req_ready), 32'd0);
            check("hold_enable", 32'(mem_enable), 32'd0);
        end
        check("txn_pending", 32'(txn_count), 32'(exp_txn));

        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_txn = (exp_txn < 16'hFFFF) ? exp_txn + 1 : 16'hFFFF;
        if (bad) exp_err = (exp_err < 8'hFF) ? exp_err + 1 : 8'hFF;

        check("txn_count", 32'(txn_count), 32'(exp_txn));
        check("err_count", 32'(err_count), 32'(exp_err));
        check("valid_after", 32'(rsp_valid), 32'd0);
        check("ready_after", 32'(req_ready), 32'd1);
        check("addr_kept", 32'(mem_addr), 32'(addr));
        check("enable_after", 32'(mem_enable), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not terminate");
    end

    initial begin
        int          lat;
        int          en_cnt;
        logic [3:0]  a;
        logic [31:0] d;

        checks   = 0;
        failures = 0;
        exp_txn  = 0;
        exp_err  = 0;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b0;
        rst_b = 1'b1; req_valid_b = 1'b0; req_write_b = 1'b0; req_addr_b = '0;
        req_wdata_b = '0; rsp_ready_b = 1'b0;

        // ---- reset state of instance A ----
        tick();
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_mem_enable", 32'(mem_enable), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_txn", 32'(txn_count), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(req_ready), 32'd1);
        tick();

        // ---- directed writes, read-back, errors ----
        do_txn(1'b1, 4'd3, 32'hDEADBEEF, 0);
        do_txn(1'b1, 4'd9, 32'h12345678, 0);
        do_txn(1'b0, 4'd9, 32'h0, 0);
        do_txn(1'b0, 4'd10, 32'hAAAA5555, 0);
        do_txn(1'b1, 4'd10, 32'h5555AAAA, 0);
        do_txn(1'b0, 4'd15, 32'h0F0F0F0F, 1);
        do_txn(1'b1, 4'd15, 32'hF0F0F0F0, 2);

        // Fill every word so the model knows all contents.
        for (int i = 0; i < DEPTH; i++) begin
            do_txn(1'b1, 4'(i), $urandom, $urandom_range(0, 2));
        end

        // ---- long backpressure on a read ----
        do_txn(1'b0, 4'd3, 32'h0, 20);

        // ---- randomized traffic ----
        for (int i = 0; i < 150; i++) begin
            do_txn(1'($urandom), 4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3));
        end

        // ---- reset coinciding with a response handshake ----
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd4; req_wdata = '0;
        tick();
        req_valid = 1'b0;
        tick();
        check("rr_resp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rsp_ready = 1'b0;
        exp_txn = 0;
        exp_err = 0;
        #1;
        check("rr_txn", 32'(txn_count), 32'd0);
        check("rr_err", 32'(err_count), 32'd0);
        check("rr_valid", 32'(rsp_valid), 32'd0);
        check("rr_ready", 32'(req_ready), 32'd1);
        check("rr_rdata", rsp_rdata, 32'd0);
        check("rr_mem_addr", 32'(mem_addr), 32'd0);
        tick();
        do_txn(1'b0, 4'd4, 32'h0, 0);

        // ---- error counter saturation ----
        for (int i = 0; i < 262; i++) begin
            do_txn(1'($urandom), 4'($urandom_range(10, 15)), $urandom, 0);
        end
        check("err_saturated", 32'(err_count), 32'hFF);

        // ---- transaction counter saturation, from a preloaded count ----
        force u_dut.txn_count = 16'hFFFA;
        tick();
        release u_dut.txn_count;
        exp_txn = 16'hFFFA;
        check("txn_preload", 32'(txn_count), 32'hFFFA);
        for (int i = 0; i < 9; i++) begin
            do_txn(1'($urandom), 4'($urandom_range(0, 15)), $urandom, 0);
        end
        check("txn_saturated", 32'(txn_count), 32'hFFFF);

        // ---- instance B: WR_CYCLES=4, RD_WAIT=2, reset during write ----
        rst_b = 1'b0;
        #1;
        check("b_ready_after_rst", 32'(req_ready_b), 32'd1);
        req_valid_b = 1'b1; req_write_b = 1'b1; req_addr_b = 4'd2; req_wdata_b = 32'hCAFEF00D;
        tick();
        req_valid_b = 1'b0;
        lat = 1;
        en_cnt = 0;
        while (rsp_valid_b !== 1'b1 && lat <= 40) begin
            if (mem_enable_b === 1'b1) en_cnt++;
            tick();
            lat++;
        end
        check("b_wr_latency", 32'(lat), 32'(WR_B + 1));
        check("b_wr_enable_cycles", 32'(en_cnt), 32'(WR_B));
        check("b_wr_rdata", rsp_rdata_b, 32'd0);
        check("b_wr_err", 32'(rsp_err_b), 32'd0);
        rsp_ready_b = 1'b1;
        tick();
        rsp_ready_b = 1'b0;
        check("b_txn_1", 32'(txn_count_b), 32'd1);

        a = 4'd5;
        d = 32'h0BADF00D;
        req_valid_b = 1'b1; req_write_b = 1'b1; req_addr_b = a; req_wdata_b = d;
        tick();
        req_valid_b = 1'b0;
        check("b_wr2_en_c1", 32'(mem_enable_b), 32'd1);
        tick();
        check("b_wr2_en_c2", 32'(mem_enable_b), 32'd1);
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        #1;
        check("b_rst_enable", 32'(mem_enable_b), 32'd0);
        check("b_rst_ready", 32'(req_ready_b), 32'd1);
        check("b_rst_valid", 32'(rsp_valid_b), 32'd0);
        check("b_rst_txn", 32'(txn_count_b), 32'd0);
        check("b_rst_err", 32'(err_count_b), 32'd0);
        tick();

        req_valid_b = 1'b1; req_write_b = 1'b0; req_addr_b = 4'd2; req_wdata_b = '0;
        tick();
        req_valid_b = 1'b0;
        lat = 1;
        en_cnt = 0;
        while (rsp_valid_b !== 1'b1 && lat <= 40) begin
            if (mem_enable_b === 1'b1) en_cnt++;
            tick();
            lat++;
        end
        check("b_rd_latency", 32'(lat), 32'(RD_B + 1));
        check("b_rd_enable_cycles", 32'(en_cnt), 32'd0);
        check("b_rd_rdata", rsp_rdata_b, 32'hCAFEF00D);
        check("b_rd_err", 32'(rsp_err_b), 32'd0);
        rsp_ready_b = 1'b1;
        tick();
        rsp_ready_b = 1'b0;
        check("b_txn_after", 32'(txn_count_b), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
